// File: rtl/lsu_byte_master.sv
// lsu_byte_master: sequences RV32I loads/stores into big-endian byte accesses on a byte-wide memory port.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned lh/lhu/sh/lw/sw
// on the error path; by default any alignment is accepted.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write, funct3     store/load select and RV32I width/sign encoding
//   req_addr, req_wdata   base byte address and store data
//   resp_valid            one-cycle response pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              request rejected without any bus operation
//   mem_rd, mem_wr        byte read/write strobes (never both high)
//   mem_addr, mem_wdata   byte address and write byte, held while strobes are low
//   mem_rdata             read byte, valid the cycle after its mem_rd cycle
module lsu_byte_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nxt;
    logic              wr_r;
    logic [2:0]        f3_r;
    logic [1:0]        cnt, cnt_d, last;
    logic [31:0]       sh_r, sh_d, pre, asm, ext;
    logic              accept, legal, mis, err, is_last, go;
    logic              mem_rd_d, mem_wr_d, resp_valid_d, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    assign req_ready = state == IDLE;
    assign accept    = req_valid & req_ready;
    assign legal     = req_write ? (funct3 inside {3'd0, 3'd1, 3'd2})
                                 : (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = (funct3[1:0] == 2'd1 && req_addr[0]) ||
                 (funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
`else
    assign mis = 1'b0;
`endif
    assign err     = !legal || mis;
    assign go      = accept && !err;
    // index of the final byte: 0, 1 or 3 for byte, half, word
    assign last    = {f3_r[1], |f3_r[1:0]};
    assign is_last = cnt == last;
    // store data left-justified so bytes always leave from [31:24]
    assign pre = funct3[1] ? req_wdata : funct3[0] ? {req_wdata[15:0], 16'h0} : {req_wdata[7:0], 24'h0};
    // the final byte arrives during the RESP cycle itself, so it is merged from the live port
    assign asm = {sh_r[23:0], mem_rdata};
    assign ext = f3_r[1] ? asm :
                 f3_r[0] ? {{16{~f3_r[2] & asm[15]}}, asm[15:0]} :
                           {{24{~f3_r[2] & asm[7]}}, asm[7:0]};
    assign resp_rdata = (resp_valid && !resp_err && !wr_r) ? ext : 32'h0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (accept ? (err ? RESP : req_write ? WRITE : READ) : IDLE) :
                    state == RESP ? IDLE :
                    is_last       ? RESP : state;
    end
    always_comb begin
        mem_rd_d     = (go && !req_write) || (state == READ && !is_last);
        mem_wr_d     = (go && req_write) || (state == WRITE && !is_last);
        mem_addr_d   = go ? req_addr :
                       ((state == READ || state == WRITE) && !is_last) ? mem_addr + ADDR_W'(1) : mem_addr;
        mem_wdata_d  = (go && req_write) ? pre[31:24] :
                       (state == WRITE && !is_last) ? sh_r[31:24] : mem_wdata;
        // loads shift in the byte returned for the previous issue slot
        sh_d         = accept ? (req_write ? pre << 8 : 32'h0) :
                       state == WRITE ? sh_r << 8 :
                       (state == READ && cnt != 2'd0) ? asm : sh_r;
        cnt_d        = (state == READ || state == WRITE) ? cnt + 2'd1 : 2'd0;
        resp_valid_d = state_nxt == RESP;
        resp_err_d   = accept && err;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            sh_r       <= 32'h0;
            cnt        <= 2'd0;
            wr_r       <= 1'b0;
            f3_r       <= 3'd0;
        end else begin
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            sh_r       <= sh_d;
            cnt        <= cnt_d;
            if (accept) begin
                wr_r <= req_write;
                f3_r <= funct3;
            end
        end
    end
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed checks of lsu_byte_master against a byte memory with one-cycle read latency.
module tb_lsu_byte_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;
    logic [7:0]  mem [256] = '{default: 8'h00};
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rd_mask, wr_mask;
    logic [31:0] addr_log [8];
    logic [7:0]  data_log [8];
    int          resp_cyc, nresp;
    logic [31:0] rdata_s;
    logic        err_s, ready_c1, ready_after;
    lsu_byte_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .funct3(funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // issue one request, scramble req_* after the accept edge, log cycles 1..7
    task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; funct3 = f; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; funct3 = 3'd7; req_addr = 32'hDEADBEEF; req_wdata = 32'h5A5A5A5A;
        rd_mask = 8'h0; wr_mask = 8'h0; resp_cyc = 0; nresp = 0;
        rdata_s = 32'hX; err_s = 1'bx; ready_c1 = 1'bx; ready_after = 1'bx;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rd_mask[c] = mem_rd; wr_mask[c] = mem_wr;
            addr_log[c] = mem_addr; data_log[c] = mem_wdata;
            if (c == 1) ready_c1 = req_ready;
            if (resp_cyc != 0 && c == resp_cyc + 1) ready_after = req_ready;
            if (resp_valid) begin
                nresp++;
                if (resp_cyc == 0) begin
                    resp_cyc = c; rdata_s = resp_rdata; err_s = resp_err;
                end
            end
        end
    endtask
    task automatic load_chk(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] exp, input int cyc);
        op(1'b0, f, a, 32'h0);
        check({tag, "_data"}, rdata_s, exp);
        check({tag, "_cyc"}, resp_cyc, cyc);
        check({tag, "_err"}, {31'h0, err_s}, 32'h0);
        check({tag, "_npulse"}, nresp, 1);
        check({tag, "_wr"}, {24'h0, wr_mask}, 32'h0);
    endtask
    initial begin
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_strobes", {28'h0, resp_valid, resp_err, mem_rd, mem_wr}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", {mem_wdata, resp_rdata[23:0]}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(1'b1, 3'd2, 32'h10, 32'h11223344);
        check("sw_wr_mask", {24'h0, wr_mask}, 32'h1E);
        check("sw_rd_mask", {24'h0, rd_mask}, 32'h0);
        check("sw_addr0", addr_log[1], 32'h10);
        check("sw_addrs", {addr_log[1][7:0], addr_log[2][7:0], addr_log[3][7:0], addr_log[4][7:0]}, 32'h10111213);
        check("sw_bytes", {data_log[1], data_log[2], data_log[3], data_log[4]}, 32'h11223344);
        check("sw_resp", {resp_cyc[7:0], 7'h0, err_s, rdata_s[15:0]}, 32'h05000000);
        check("sw_rdata", rdata_s, 32'h0);
        check("sw_busy", {31'h0, ready_c1}, 32'h0);
        check("sw_ready_after", {31'h0, ready_after}, 32'h1);
        op(1'b1, 3'd0, 32'h13, 32'hFFFFFF80);
        check("sb_wr_mask", {24'h0, wr_mask}, 32'h02);
        check("sb_byte", {addr_log[1][23:0], data_log[1]}, 32'h00001380);
        check("sb_cyc", resp_cyc, 2);
        check("mem_13", {24'h0, mem[8'h13]}, 32'h80);
        load_chk("lb13", 3'd0, 32'h13, 32'hFFFFFF80, 2);
        check("lb13_rd_mask", {24'h0, rd_mask}, 32'h02);
        load_chk("lbu13", 3'd4, 32'h13, 32'h00000080, 2);
        load_chk("lb12", 3'd0, 32'h12, 32'h00000033, 2);
        op(1'b1, 3'd1, 32'h10, 32'h12349A22);
        check("sh_wr_mask", {24'h0, wr_mask}, 32'h06);
        check("sh_bytes", {data_log[1], data_log[2], addr_log[1][7:0], addr_log[2][7:0]}, 32'h9A221011);
        check("sh_cyc", resp_cyc, 3);
        load_chk("lh10", 3'd1, 32'h10, 32'hFFFF9A22, 3);
        check("lh10_rd_mask", {24'h0, rd_mask}, 32'h06);
        load_chk("lhu10", 3'd5, 32'h10, 32'h00009A22, 3);
        load_chk("lh12", 3'd1, 32'h12, 32'h00003380, 3);
        op(1'b1, 3'd0, 32'h13, 32'h00000044);
        load_chk("lw10", 3'd2, 32'h10, 32'h9A223344, 5);
        check("lw10_rd_mask", {24'h0, rd_mask}, 32'h1E);
        check("lw10_addr_last", addr_log[4], 32'h13);
        op(1'b0, 3'd3, 32'h10, 32'h0);
        check("ld3_resp", {resp_cyc[7:0], 7'h0, err_s, 15'h0, ready_after}, 32'h01010001);
        check("ld3_rdata", rdata_s, 32'h0);
        check("ld3_strobes", {16'h0, rd_mask, wr_mask}, 32'h0);
        op(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF);
        check("st4_resp", {resp_cyc[7:0], 7'h0, err_s, 15'h0, ready_after}, 32'h01010001);
        check("st4_rdata", rdata_s, 32'h0);
        check("st4_strobes", {16'h0, rd_mask, wr_mask}, 32'h0);
        check("st4_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'h9A223344);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mr_wr_c1", {31'h0, mem_wr}, 32'h1);
        @(negedge clk);
        check("mr_wr_c2", {31'h0, mem_wr}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_strobes", {29'h0, mem_wr, mem_rd, resp_valid}, 32'h0);
        check("mr_addr", {mem_addr[23:0], mem_wdata}, 32'h0);
        check("mr_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || mem_wr) nresp++;
        end
        check("mr_no_resp", nresp, 0);
        check("mr_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'hAA000000);
        load_chk("lw20", 3'd2, 32'h20, 32'hAA000000, 5);
        op(1'b1, 3'd0, 32'h14, 32'h00000055);
        op(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000081);
        op(1'b1, 3'd0, 32'h00000000, 32'h00000002);
        check("wrap_mem", {16'h0, mem[8'hFF], mem[8'h00]}, 32'h8102);
`ifdef LSU_MISALIGN_CHECK_EN
        op(1'b0, 3'd2, 32'h11, 32'h0);
        check("lw11_err", {resp_cyc[7:0], 7'h0, err_s, rdata_s[15:0]}, 32'h01010000);
        check("lw11_strobes", {16'h0, rd_mask, wr_mask}, 32'h0);
        op(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
        check("lhwrap_err", {resp_cyc[7:0], 7'h0, err_s, rdata_s[15:0]}, 32'h01010000);
        check("lhwrap_strobes", {16'h0, rd_mask, wr_mask}, 32'h0);
`else
        load_chk("lw11", 3'd2, 32'h11, 32'h22334455, 5);
        check("lw11_rd_mask", {24'h0, rd_mask}, 32'h1E);
        check("lw11_addrs", {addr_log[1][15:0], addr_log[4][15:0]}, 32'h00110014);
        load_chk("lhwrap", 3'd1, 32'hFFFFFFFF, 32'hFFFF8102, 3);
        check("lhwrap_addr0", addr_log[1], 32'hFFFFFFFF);
        check("lhwrap_addr1", addr_log[2], 32'h00000000);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
